// File: rtl/alu_result_stage.sv
// alu_result_stage: final ALU stage. Computes a 4-bit result and its {N,Z,C,V}
// flags from preprocessed operands and queues them in a DEPTH-entry FIFO.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   AMod, BMod, Op   operands and opcode (Op[2]=0 add, Op[2]=1 logic op)
//   in_valid/ready   input handshake; in_ready depends only on stored state
//   R, flags         result and {N,Z,C,V} at the FIFO head (zero when empty)
//   out_valid/ready  output handshake
//   acc_count        saturating count of accepted operations
module alu_result_stage #(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] AMod,
    input  logic [3:0] BMod,
    input  logic [2:0] Op,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] R,
    output logic [3:0] flags,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] acc_count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [4:0]      sum5;
    logic [3:0]      res;
    logic            carry;
    logic            ovf;
    logic [7:0]      entry;

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [7:0]      acc_q, acc_d;
    logic            push;
    logic            pop;

    // Result and flag computation.
    always_comb begin
        sum5  = {1'b0, AMod} + {1'b0, BMod};
        res   = 4'b0000;
        carry = 1'b0;
        ovf   = 1'b0;
        if (!Op[2]) begin
            res   = sum5[3:0];
            carry = sum5[4];
            // Signed overflow: same-sign operands producing a different-sign result.
            ovf   = (AMod[3] == BMod[3]) && (res[3] != AMod[3]);
        end else begin
            case (Op[1:0])
                2'b00:   res = AMod & BMod;
                2'b01:   res = AMod | BMod;
                2'b10:   res = AMod ^ BMod;
                default: res = ~(AMod | BMod);
            endcase
        end
        entry = {res, res[3], (res == 4'b0000), carry, ovf};
    end

    assign in_ready  = (count_q < CntW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head is gated by out_valid so outputs read zero after reset and when empty.
    assign R         = out_valid ? mem_q[rd_ptr_q][7:4] : 4'b0000;
    assign flags     = out_valid ? mem_q[rd_ptr_q][3:0] : 4'b0000;
    assign acc_count = acc_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        acc_d    = acc_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            if (acc_q != 8'hFF) begin
                acc_d = acc_q + 8'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    // Writing only on push keeps idle-cycle data inputs out of the buffer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

endmodule
